// File: rtl/arbitro_rr_4.sv
// Four-channel round-robin arbiter driving the select of the downstream 4:1 data mux.
// Grants are registered, held up to HOLD cycles, and always followed by one idle gap cycle.
module arbitro_rr_4 #(
  parameter int HOLD = 8,
  parameter int CW   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [1:0] o_sel,
  output logic [3:0] o_gnt,
  output logic       o_busy
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_last;

  logic            w_found;
  logic [1:0]      w_idx;
  logic [1:0]      w_cand;

  // Search last+1, last+2, last+3, last; the 2-bit add wraps modulo 4.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 2'd3;
      o_sel   <= 2'd0;
      o_gnt   <= 4'd0;
      o_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            o_gnt   <= 4'b0001 << w_idx;
            o_sel   <= w_idx;
            o_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_GRANT;
          end else begin
            o_gnt  <= 4'd0;
            o_busy <= 1'b0;
          end
        end
        S_GRANT: begin
          // o_sel is left untouched on release so the mux input stays stable.
          if (!i_req[o_sel] || (r_cnt == HOLD_LAST)) begin
            o_gnt   <= 4'd0;
            o_busy  <= 1'b0;
            r_last  <= o_sel;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_gnt   <= 4'd0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/arbitro_rr_4.md
Name: arbitro_rr_4

Overview:
Four-channel round-robin arbiter that generates the 2-bit select feeding the 4-to-1 data multiplexer stage (Demux_4_a_1) directly downstream of it.
- Up to four sources raise requests; the block grants one at a time and drives the select so the mux routes that source's n-bit data.
- Each grant is held until the source drops its request or a maximum dwell time expires.
- Rotating priority guarantees no starvation.

Parameters:
HOLD, 8, maximum consecutive cycles a single grant may be held; legal range 1..256.
CW, 8, width of the internal dwell counter; must satisfy 2^CW >= HOLD.

Ports:
i_clk  input  1  system clock; all state updates on rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_req  input  4  request per channel; bit k = channel k (matches mux data input k).
o_sel  output 2  binary index of granted channel; drives the mux select input.
o_gnt  output 4  one-hot grant; all zeros when no grant is active.
o_busy output 1  high while a grant is active (equals OR of o_gnt).

Behaviour:
- Reset (async, immediate, no clock needed):
  - o_sel=2'b00, o_gnt=4'b0000, o_busy=0.
  - State IDLE, dwell counter=0, last-served pointer=3, so channel 0 has top priority on the first arbitration.
- All outputs are registered. No combinational path from i_req to any output.
- State IDLE, at each rising edge:
  - If i_req==0: stay IDLE; o_gnt=0; o_sel holds its previous value (the mux input stays stable, never forced to 0).
  - Else pick the first requesting channel searching last+1, last+2, last+3, last (mod 4).
  - Register o_gnt=one-hot(idx), o_sel=idx, o_busy=1, counter=0; go to GRANT.
  - Latency: request visible before edge N gives grant valid after edge N (1 cycle).
- State GRANT, at each rising edge:
  - Release when i_req[o_sel]==0, or when counter==HOLD-1.
  - On release: o_gnt=0, o_busy=0, last=o_sel, counter=0, go to IDLE; o_sel unchanged.
  - Otherwise counter increments by 1 and the outputs hold.
  - A grant therefore lasts at most HOLD cycles (HOLD=1 gives exactly one cycle).
- Mandatory gap: after every release there is exactly one cycle with o_gnt=0 before any new grant. With continuous requests, the grant period is HOLD+1 cycles.
- Requests from non-granted channels that appear or vanish during GRANT have no effect until the next IDLE arbitration.
- Requests are level-sensitive. A request dropped during the gap cycle is not granted.
- Invariants: o_gnt is always zero or one-hot; o_busy==|o_gnt; when o_busy=1, o_gnt[o_sel]==1.
- Reset asserted mid-grant: all outputs clear asynchronously. After reset release, arbitration restarts at channel 0 regardless of history.
- Counter never wraps, because release occurs at HOLD-1.

Test Plan:
- Reset then i_req=4'b0001 held, HOLD=8 → one cycle later o_gnt=0001, o_sel=00, o_busy=1.
  - Grant lasts 8 cycles, 1 gap cycle, then re-granted to channel 0 (only requester).
- i_req=4'b1111 held, HOLD=8 → grants to channels 0,1,2,3,0 in order, each 8 cycles, separated by 1 zero cycle; o_sel sequence 00,01,10,11,00 (period 9).
- Early release: i_req=0100 for 3 cycles then 0000 → o_gnt=0100 for exactly 3 cycles, then 0; o_sel stays 10 while idle.
- Fairness: after serving channel 1, apply i_req=1011 → next grant is channel 3 (o_sel=11), then channel 0, then channel 1.
- Async reset pulse mid-grant (no clock edge) → o_gnt=0, o_busy=0, o_sel=00 immediately; with i_req=1111 afterwards, the first grant goes to channel 0.
- HOLD=1 build, i_req=1111 → one-cycle grants alternating with one-cycle gaps; o_gnt never asserts two bits at once.
